marv32_alu_seq: RTL and testbench

MARV32_ALU_SEQ -- requirements
Module: marv32_alu_seq

---
 rtl/marv32_alu_seq.sv | 135 +++++++++++++
 tb/tb_marv32_alu_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/marv32_alu_seq.sv
// Request sequencer for marv32_alu: registers operands, captures results into a response FIFO.
// Optional golden-model self-check is enabled by defining MARV32_ALU_SEQ_CHECK_EN.
module marv32_alu_seq #(
  parameter int RSP_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [31:0]          req_op_1_in,
  input  logic [31:0]          req_op_2_in,
  input  logic [3:0]           req_opcode_in,
  output logic [31:0]          alu_op_1_out,
  output logic [31:0]          alu_op_2_out,
  output logic [3:0]           alu_opcode_out,
  input  logic [31:0]          alu_result_in,
  output logic                 rsp_valid_out,
  input  logic                 rsp_ready_in,
  output logic [31:0]          rsp_result_out,
  output logic [3:0]           rsp_opcode_out,
  output logic                 busy_out,
  output logic [CNT_WIDTH-1:0] done_cnt_out,
  output logic                 mismatch_out
);

  localparam int PTR_W = $clog2(RSP_DEPTH);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e                 state_q;
  logic [31:0]            op_1_q, op_2_q;
  logic [3:0]             opcode_q;
  logic [31:0]            res_mem [RSP_DEPTH];
  logic [3:0]             opc_mem [RSP_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]         count_q, count_d;
  logic [CNT_WIDTH-1:0]   done_cnt_q, done_cnt_d;
  logic [PTR_W+1:0]       occupancy;
  logic                   push, pop, accept, fifo_nonempty;

  assign push          = (state_q == EXEC);
  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty && rsp_ready_in;

  // Occupancy includes the result still in the ALU, so an accepted request always has a slot.
  assign occupancy     = {1'b0, count_q} + (PTR_W+2)'(push) - (PTR_W+2)'(pop);
  assign req_ready_out = (occupancy < (PTR_W+2)'(RSP_DEPTH));
  assign accept        = req_valid_in && req_ready_out;

  assign count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign done_cnt_d = done_cnt_q + CNT_WIDTH'(pop);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      op_1_q   <= '0;
      op_2_q   <= '0;
      opcode_q <= '0;
    end else begin
      state_q <= accept ? EXEC : IDLE;
      if (accept) begin
        op_1_q   <= req_op_1_in;
        op_2_q   <= req_op_2_in;
        opcode_q <= req_opcode_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      res_mem[wr_ptr_q] <= alu_result_in;
      opc_mem[wr_ptr_q] <= opcode_q;
    end
  end

  assign alu_op_1_out   = op_1_q;
  assign alu_op_2_out   = op_2_q;
  assign alu_opcode_out = opcode_q;
  assign rsp_valid_out  = fifo_nonempty;
  assign rsp_result_out = fifo_nonempty ? res_mem[rd_ptr_q] : '0;
  assign rsp_opcode_out = fifo_nonempty ? opc_mem[rd_ptr_q] : '0;
  assign busy_out       = push || fifo_nonempty;
  assign done_cnt_out   = done_cnt_q;

`ifdef MARV32_ALU_SEQ_CHECK_EN
  logic [31:0] gold;
  logic        gold_def;
  logic        mismatch_q;

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    gold     = '0;
    gold_def = 1'b1;
    case (opcode_q)
      4'b0000: gold = op_1_q + op_2_q;
      4'b1000: gold = op_1_q - op_2_q;
      4'b0001: gold = op_1_q << op_2_q[4:0];
      4'b0010: gold = {31'b0, $signed(op_1_q) < $signed(op_2_q)};
      4'b0011: gold = {31'b0, op_1_q < op_2_q};
      4'b0100: gold = op_1_q ^ op_2_q;
      4'b0101: gold = op_1_q >> op_2_q[4:0];
      4'b1101: gold = $unsigned($signed(op_1_q) >>> op_2_q[4:0]);
      4'b0110: gold = op_1_q | op_2_q;
      4'b0111: gold = op_1_q & op_2_q;
      default: gold_def = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) mismatch_q <= 1'b0;
    else if (push && gold_def && (alu_result_in != gold)) mismatch_q <= 1'b1;
  end

  assign mismatch_out = mismatch_q;
`else
  assign mismatch_out = 1'b0;
`endif

endmodule

// File: tb/tb_marv32_alu_seq.sv
// Self-checking bench for marv32_alu_seq: acts as the ALU, keeps a queue-based reference model,
// and compares every output on each falling edge; directed cases pin literal results.
module tb_marv32_alu_seq;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
`ifdef MARV32_ALU_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          reset_n_in = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [31:0]   req_op_1_in = '0, req_op_2_in = '0;
  logic [3:0]    req_opcode_in = '0;
  logic [31:0]   alu_op_1_out, alu_op_2_out;
  logic [3:0]    alu_opcode_out;
  logic [31:0]   alu_result_in;
  logic          rsp_valid_out;
  logic          rsp_ready_in = 1'b0;
  logic [31:0]   rsp_result_out;
  logic [3:0]    rsp_opcode_out;
  logic          busy_out;
  logic [CW-1:0] done_cnt_out;
  logic          mismatch_out;

  int n_vec = 0;
  int n_err = 0;
  int dut_acc = 0;
  bit corrupt_en = 1'b0;

  marv32_alu_seq #(.RSP_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_op_1_in(req_op_1_in), .req_op_2_in(req_op_2_in), .req_opcode_in(req_opcode_in),
    .alu_op_1_out(alu_op_1_out), .alu_op_2_out(alu_op_2_out), .alu_opcode_out(alu_opcode_out),
    .alu_result_in(alu_result_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_result_out(rsp_result_out), .rsp_opcode_out(rsp_opcode_out),
    .busy_out(busy_out), .done_cnt_out(done_cnt_out), .mismatch_out(mismatch_out)
  );

  always #5 clk_in = ~clk_in;

  // RISC-V ALU semantics; undefined opcodes get an arbitrary but deterministic result.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] opc);
    int unsigned sh = int'(b[4:0]);
    case (opc)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd1:  return a << sh;
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd13: return $unsigned($signed(a) >>> sh);
      4'd6:  return a | b;
      4'd7:  return a & b;
      default: return {a[15:0], b[15:0]} ^ {28'h0, opc};
    endcase
  endfunction

  function automatic bit is_bad(input logic [31:0] a, input logic [31:0] b, input logic [3:0] opc);
    return corrupt_en && a == 32'd1 && b == 32'd2 && opc == 4'd0;
  endfunction

  assign alu_result_in = is_bad(alu_op_1_out, alu_op_2_out, alu_opcode_out) ? 32'hDEADBEEF
                         : alu_ref(alu_op_1_out, alu_op_2_out, alu_opcode_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered responses in a queue, plus at most one result in flight.
  logic [31:0] q_res[$];
  logic [3:0]  q_op[$];
  bit          infl = 1'b0, infl_bad = 1'b0, mism_m = 1'b0;
  logic [31:0] infl_res = '0;
  logic [3:0]  infl_op = '0;
  int          done_m = 0;

  function automatic bit exp_ready();
    int sz = q_res.size();
    return (sz + int'(infl) - int'(sz > 0 && rsp_ready_in)) < DEPTH;
  endfunction

  always @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      q_res.delete();
      q_op.delete();
      infl   = 1'b0;
      done_m = 0;
      mism_m = 1'b0;
    end else begin
      bit acc;
      acc = req_valid_in && exp_ready();
      if (q_res.size() > 0 && rsp_ready_in) begin
        void'(q_res.pop_front());
        void'(q_op.pop_front());
        done_m++;
      end
      if (infl) begin
        q_res.push_back(infl_res);
        q_op.push_back(infl_op);
        if (infl_bad) mism_m = CHK;
      end
      infl = acc;
      if (acc) begin
        infl_op  = req_opcode_in;
        infl_bad = is_bad(req_op_1_in, req_op_2_in, req_opcode_in);
        infl_res = infl_bad ? 32'hDEADBEEF : alu_ref(req_op_1_in, req_op_2_in, req_opcode_in);
      end
    end
  end

  always @(negedge clk_in) begin
    int sz;
    sz = q_res.size();
    check("req_ready", req_ready_out, exp_ready());
    check("rsp_valid", rsp_valid_out, sz > 0);
    if (sz > 0) begin
      check("rsp_result", rsp_result_out, q_res[0]);
      check("rsp_opcode", rsp_opcode_out, q_op[0]);
    end
    check("busy", busy_out, infl || sz > 0);
    check("done_cnt", done_cnt_out, done_m[CW-1:0]);
    check("mismatch", mismatch_out, mism_m);
    if (req_valid_in && req_ready_out) dut_acc++;
  end

  // Present inputs for one rising edge; returns 1 ns after that edge.
  task automatic drive(input bit v, input logic [3:0] opc, input logic [31:0] a,
                       input logic [31:0] b, input bit rr);
    req_valid_in  = v;
    req_opcode_in = opc;
    req_op_1_in   = a;
    req_op_2_in   = b;
    rsp_ready_in  = rr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 32'd0, rr);
  endtask

  task automatic do_reset();
    #1 reset_n_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1 reset_n_in = 1'b1;
  endtask

  initial begin
    int acc0;
    logic [3:0] ops[10];
    ops = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7};

    do_reset();
    check("rst_ready", req_ready_out, 1'b1);
    check("rst_alu_op1", alu_op_1_out, 32'd0);
    check("rst_alu_opc", alu_opcode_out, 4'd0);
    check("rst_rsp_result", rsp_result_out, 32'd0);

    // ADD latency, then SUB and SRA in issue order.
    drive(1'b1, 4'b0000, 32'd1, 32'd2, 1'b0);
    check("add_lat_not_yet", rsp_valid_out, 1'b0);
    drive(1'b1, 4'b1000, 32'd3, 32'd2, 1'b0);
    check("add_lat_valid", rsp_valid_out, 1'b1);
    check("add_result", rsp_result_out, 32'h00000003);
    check("add_opcode", rsp_opcode_out, 4'b0000);
    drive(1'b1, 4'b1101, 32'h80000000, 32'd4, 1'b0);
    idle(1, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("sub_result", rsp_result_out, 32'h00000001);
    check("sub_opcode", rsp_opcode_out, 4'b1000);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("sra_result", rsp_result_out, 32'hF8000000);
    check("sra_opcode", rsp_opcode_out, 4'b1101);
    idle(2, 1'b1);
    check("drained", rsp_valid_out, 1'b0);

    // Backpressure: five requests, consumer stalled.
    do_reset();
    acc0 = dut_acc;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd0, 32'(i), 32'd10, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd0, 32'd4, 32'd10, 1'b0);
    check("bp_accepted", 32'(dut_acc - acc0), 32'd4);
    check("bp_ready_low", req_ready_out, 1'b0);
    check("bp_head_stable", rsp_result_out, 32'd10);
    drive(1'b1, 4'd0, 32'd4, 32'd10, 1'b1);
    idle(8, 1'b1);
    check("bp_accepted_all", 32'(dut_acc - acc0), 32'd5);
    check("bp_done_cnt", done_cnt_out, 16'd5);

    // Full FIFO with simultaneous push and pop every cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd4, 32'(i), 32'hFF, 1'b0);
    idle(2, 1'b0);
    check("full_ready_low", req_ready_out, 1'b0);
    acc0 = dut_acc;
    for (int i = 0; i < 8; i++) drive(1'b1, 4'd6, 32'(i << 8), 32'd1, 1'b1);
    check("full_pushpop_acc", 32'(dut_acc - acc0), 32'd8);
    idle(8, 1'b1);
    check("full_done_cnt", done_cnt_out, 16'd17);

    // Reset with two buffered results.
    drive(1'b1, 4'd0, 32'd7, 32'd8, 1'b0);
    drive(1'b1, 4'd0, 32'd9, 32'd8, 1'b0);
    idle(1, 1'b0);
    #2 reset_n_in = 1'b0;
    #1;
    check("rst_mid_valid", rsp_valid_out, 1'b0);
    check("rst_mid_done", done_cnt_out, 16'd0);
    check("rst_mid_busy", busy_out, 1'b0);
    @(posedge clk_in);
    #1 reset_n_in = 1'b1;
    idle(3, 1'b1);
    check("rst_no_stale", rsp_valid_out, 1'b0);

    // Corrupted ALU result on ADD 1+2.
    corrupt_en = 1'b1;
    drive(1'b1, 4'd0, 32'd1, 32'd2, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    check("bad_result", rsp_result_out, 32'hDEADBEEF);
    check("bad_mismatch", mismatch_out, CHK);
    corrupt_en = 1'b0;
    drive(1'b1, 4'd0, 32'd5, 32'd6, 1'b1);
    idle(3, 1'b1);
    check("bad_sticky", mismatch_out, CHK);
    do_reset();
    check("bad_cleared", mismatch_out, 1'b0);

    // Random traffic, including undefined opcodes.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] opc;
      opc = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : ops[$urandom_range(0, 9)];
      drive($urandom_range(0, 3) != 0, opc, $urandom(), $urandom(), $urandom_range(0, 2) != 0);
    end
    idle(10, 1'b1);
    check("rand_drained", rsp_valid_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
